// File: rtl/descrypt_pkt_parser.sv
// descrypt_pkt_parser: parses and checksums host packets, forwarding body bytes downstream
module descrypt_pkt_parser #(
  parameter int DISABLE_CHECKSUM = 0,
  parameter int PKT_MAX_LEN = 65536
) (
  input  logic        PKT_COMM_CLK,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        empty,
  output logic        rd_en,
  output logic [7:0]  dout,
  output logic        wr_en,
  input  logic        full,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic        pkt_end,
  output logic        pkt_done,
  output logic [7:0]  pkt_comm_status
);
  typedef enum logic [2:0] {HDR, HDR_CSUM, BODY, BODY_CSUM, ERR} state_t;
  state_t state;
  logic [23:0] cnt, len;
  logic [7:0] ver, typ;
  logic [15:0] id;
  logic [31:0] sum, rx, add, sum_nxt, rx_nxt;
  logic csum_ok;
  logic [3:0] hdr_err;
  assign rd_en = !rst && !empty && state != ERR && !(state == BODY && full);
  assign wr_en = rd_en && state == BODY;
  assign dout = din;
  assign pkt_end = wr_en && cnt == len - 24'd1;
  // Each byte lands in its little-endian lane of a 32-bit word, so a running sum equals the word sum
  always_comb begin
    add = 32'(din) << {cnt[1:0], 3'b000};
    sum_nxt = sum + add;
    rx_nxt = rx | add;
    csum_ok = DISABLE_CHECKSUM != 0 || ~sum == rx_nxt;
    hdr_err = {!csum_ok, len == 24'd0 || {8'd0, len} > 32'(PKT_MAX_LEN),
               typ == 8'd0 || typ > 8'd3, ver != 8'd2};
  end
  always_ff @(posedge PKT_COMM_CLK) begin
    if (rst) begin
      state <= HDR;
      cnt <= '0;
      len <= '0;
      ver <= '0;
      typ <= '0;
      id <= '0;
      sum <= '0;
      rx <= '0;
      pkt_type <= '0;
      pkt_id <= '0;
      pkt_done <= 1'b0;
      pkt_comm_status <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (rd_en) begin
        case (state)
          HDR: begin
            sum <= sum_nxt;
            if (cnt == 24'd0) ver <= din;
            if (cnt == 24'd1) typ <= din;
            if (cnt == 24'd4) len[7:0] <= din;
            if (cnt == 24'd5) len[15:8] <= din;
            if (cnt == 24'd6) len[23:16] <= din;
            if (cnt == 24'd8) id[7:0] <= din;
            if (cnt == 24'd9) id[15:8] <= din;
            cnt <= cnt == 24'd9 ? '0 : cnt + 24'd1;
            if (cnt == 24'd9) begin
              state <= HDR_CSUM;
              rx <= '0;
            end
          end
          HDR_CSUM: begin
            rx <= rx_nxt;
            cnt <= cnt + 24'd1;
            if (cnt == 24'd3) begin
              cnt <= '0;
              sum <= '0;
              if (|hdr_err) begin
                pkt_comm_status[3:0] <= pkt_comm_status[3:0] | hdr_err;
                state <= ERR;
              end else begin
                pkt_type <= typ;
                pkt_id <= id;
                state <= BODY;
              end
            end
          end
          BODY: begin
            sum <= sum_nxt;
            cnt <= cnt + 24'd1;
            if (cnt == len - 24'd1) begin
              cnt <= '0;
              rx <= '0;
              state <= BODY_CSUM;
            end
          end
          BODY_CSUM: begin
            rx <= rx_nxt;
            cnt <= cnt + 24'd1;
            if (cnt == 24'd3) begin
              cnt <= '0;
              sum <= '0;
              if (csum_ok) begin
                pkt_done <= 1'b1;
                state <= HDR;
              end else begin
                pkt_comm_status[4] <= 1'b1;
                state <= ERR;
              end
            end
          end
          ERR: ;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_descrypt_pkt_parser.sv
// tb_descrypt_pkt_parser: FWFT feeder plus scoreboard monitor for two parser instances
module tb_descrypt_pkt_parser;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, sel = 1'b1, full = 1'b0, empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic rd0, wr0, pe0, dn0, rd1, wr1, pe1, dn1;
  logic [7:0] do0, ty0, st0, do1, ty1, st1;
  logic [15:0] id0, id1;
  bq_t in_q;
  logic [8:0] exp_q[$];
  int checks = 0, errors = 0, nbeats = 0, ndone = 0, stall_after = 0, stall_left = 0;
  bit took = 1'b0;
  descrypt_pkt_parser #(.DISABLE_CHECKSUM(0)) u0 (.PKT_COMM_CLK(clk), .rst(rst), .din(din),
    .empty(sel | empty), .rd_en(rd0), .dout(do0), .wr_en(wr0), .full(full), .pkt_type(ty0),
    .pkt_id(id0), .pkt_end(pe0), .pkt_done(dn0), .pkt_comm_status(st0));
  descrypt_pkt_parser #(.DISABLE_CHECKSUM(1)) u1 (.PKT_COMM_CLK(clk), .rst(rst), .din(din),
    .empty(!sel | empty), .rd_en(rd1), .dout(do1), .wr_en(wr1), .full(full), .pkt_type(ty1),
    .pkt_id(id1), .pkt_end(pe1), .pkt_done(dn1), .pkt_comm_status(st1));
  wire rd = sel ? rd1 : rd0;
  wire wr = sel ? wr1 : wr0;
  wire pe = sel ? pe1 : pe0;
  wire dn = sel ? dn1 : dn0;
  wire [7:0] dq = sel ? do1 : do0;
  wire [7:0] ty = sel ? ty1 : ty0;
  wire [7:0] st = sel ? st1 : st0;
  wire [15:0] idv = sel ? id1 : id0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] csum(input bq_t b);
    logic [31:0] s = 0, w;
    for (int i = 0; i < b.size(); i += 4) begin
      w = 0;
      for (int j = 0; j < 4; j++) if (i + j < b.size()) w[8*j +: 8] = b[i+j];
      s += w;
    end
    return ~s;
  endfunction
  // mode: 0 correct checksums, 1 all-zero checksums, 2 one body-checksum bit flipped
  task automatic send(input logic [7:0] v, input logic [7:0] t, input logic [15:0] id,
                      input bq_t body, input int mode, input bit ok);
    bq_t h;
    logic [23:0] len;
    logic [31:0] hc, bc;
    logic last;
    len = 24'(body.size());
    h = '{v, t, 8'h00, 8'h00, len[7:0], len[15:8], len[23:16], 8'h00, id[7:0], id[15:8]};
    hc = mode == 1 ? 32'h0 : csum(h);
    bc = mode == 1 ? 32'h0 : csum(body) ^ (mode == 2 ? 32'h100 : 32'h0);
    foreach (h[i]) in_q.push_back(h[i]);
    for (int k = 0; k < 4; k++) in_q.push_back(hc[8*k +: 8]);
    if (ok) begin
      foreach (body[i]) begin
        last = (i == body.size() - 1);
        in_q.push_back(body[i]);
        exp_q.push_back({last, body[i]});
      end
      for (int k = 0; k < 4; k++) in_q.push_back(bc[8*k +: 8]);
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    in_q.delete();
    exp_q.delete();
    @(posedge clk); #2;
    nbeats = 0;
    ndone = 0;
    rst = 1'b0;
  endtask
  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (in_q.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    chk("drain", in_q.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    if (took) void'(in_q.pop_front());
    #1;
    full = stall_left > 0 && nbeats >= stall_after;
    if (full) stall_left--;
    empty = in_q.size() == 0;
    din = empty ? 8'h00 : in_q[0];
    @(negedge clk);
    took = rd;
  end
  initial forever begin
    @(negedge clk);
    if (wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: got unexpected byte %h, expected none", dq);
      end else chk("beat", {pe, dq}, exp_q.pop_front());
      nbeats++;
    end
    if (dn) ndone++;
    if (full) chk("stall_rd_en", rd, 0);
  end
  initial begin
    bq_t a, b, c, d, e;
    a = '{8'hC7, 8'h01, 8'h0A, 8'h00};
    repeat (50) a.push_back(8'hBB);
    a.push_back(8'hCC);
    b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBB};
    c = '{8'h6D, 8'h79, 8'h70, 8'h77, 8'h64, 8'h31, 8'h32, 8'h33};
    for (int i = 0; i < 15; i++) d.push_back(8'(8'h10 + i));
    send(8'd2, 8'd3, 16'hCDAB, a, 1, 1);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rd, 0);
    chk("rst_wr_en", wr, 0);
    chk("rst_pkt_end", pe, 0);
    chk("rst_type", ty, 0);
    chk("rst_id", idv, 0);
    chk("rst_status", st, 0);
    chk("rst_done", dn, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_drain(300);
    chk("a_left", exp_q.size(), 0);
    chk("a_beats", nbeats, 55);
    chk("a_done", ndone, 1);
    chk("a_type", ty, 8'h03);
    chk("a_id", idv, 16'hCDAB);
    chk("a_status", st, 0);
    sel = 1'b0;
    do_reset();
    stall_after = 9;
    stall_left = 5;
    send(8'd2, 8'd2, 16'h0102, b, 0, 1);
    send(8'd2, 8'd1, 16'h0007, c, 0, 1);
    wait_drain(200);
    chk("b_left", exp_q.size(), 0);
    chk("b_beats", nbeats, 14);
    chk("b_done", ndone, 2);
    chk("b_stall_used", stall_left, 0);
    chk("b_type", ty, 8'h01);
    chk("b_id", idv, 16'h0007);
    chk("b_status", st, 0);
    do_reset();
    send(8'd3, 8'd3, 16'h1111, d, 0, 0);
    send(8'd2, 8'd3, 16'h2222, d, 0, 1);
    repeat (60) @(negedge clk);
    chk("ver_status", st, 8'h01);
    chk("ver_held", in_q.size(), 33);
    chk("ver_beats", nbeats, 0);
    chk("ver_done", ndone, 0);
    do_reset();
    @(negedge clk);
    chk("ver_rst_status", st, 0);
    send(8'd2, 8'd3, 16'h2222, d, 0, 1);
    wait_drain(100);
    chk("c_left", exp_q.size(), 0);
    chk("c_done", ndone, 1);
    chk("c_status", st, 0);
    chk("c_type", ty, 8'h03);
    chk("c_id", idv, 16'h2222);
    do_reset();
    send(8'd2, 8'd3, 16'h3333, d, 2, 1);
    wait_drain(100);
    chk("bcs_left", exp_q.size(), 0);
    chk("bcs_beats", nbeats, 15);
    chk("bcs_done", ndone, 0);
    chk("bcs_status", st, 8'h10);
    do_reset();
    send(8'd2, 8'd3, 16'h4444, e, 0, 0);
    repeat (30) @(negedge clk);
    chk("len0_status", st, 8'h04);
    do_reset();
    send(8'd2, 8'd5, 16'h5555, d, 0, 0);
    repeat (30) @(negedge clk);
    chk("type5_status", st, 8'h02);
    chk("type5_beats", nbeats, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
